// File: rtl/uart_rx_packet_assembler_if.sv
// Handshake bundle between the UART byte source, the packet assembler
// and the downstream packet consumer.
interface uart_rx_packet_assembler_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;

    modport master (
        output rx_data,
        output rx_valid,
        output pkt_ready,
        input  pkt_data,
        input  pkt_valid,
        input  pkt_last
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  pkt_ready,
        output pkt_data,
        output pkt_valid,
        output pkt_last
    );
endinterface

// File: rtl/uart_rx_packet_assembler.sv
// Frames UART bytes into SYNC/len/payload/xor packets and streams out
// the payload only after the length and checksum have been verified.
module uart_rx_packet_assembler #(
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hAA,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_rx_packet_assembler_if.slave   io,
    output logic                        err_checksum,
    output logic                        err_length,
    output logic                        err_timeout,
    output logic                        err_overrun,
    output logic                        busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAXL   = 8'(MAX_LEN);
    localparam logic [CW-1:0] TO_END = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    rd_q, rd_d;
    logic [7:0]    csum_q, csum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ecs_q, ecs_d;
    logic          elen_q, elen_d;
    logic          eto_q, eto_d;
    logic          eov_q, eov_d;
    logic          wr_en;
    logic          timed_out;
    logic          last_rd;
    logic [7:0]    buf_q [MAX_LEN];

    // An arriving byte always beats an expiring counter.
    assign timed_out = (cnt_q == TO_END) && !io.rx_valid;
    assign last_rd   = (rd_q == len_q - 8'd1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q + CW'(1);
        wr_en   = 1'b0;
        ecs_d   = 1'b0;
        elen_d  = 1'b0;
        eto_d   = 1'b0;
        eov_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (io.rx_valid && io.rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (io.rx_valid) begin
                    cnt_d  = '0;
                    len_d  = io.rx_data;
                    csum_d = io.rx_data;
                    if (io.rx_data == 8'd0 || io.rx_data > MAXL) begin
                        elen_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end else if (timed_out) begin
                    eto_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (io.rx_valid) begin
                    cnt_d  = '0;
                    wr_en  = 1'b1;
                    csum_d = csum_q ^ io.rx_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q) begin
                        state_d = S_CHECK;
                    end
                end else if (timed_out) begin
                    eto_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (io.rx_valid) begin
                    cnt_d = '0;
                    if (io.rx_data == csum_q) begin
                        rd_d    = 8'd0;
                        state_d = S_DRAIN;
                    end else begin
                        ecs_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (timed_out) begin
                    eto_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                cnt_d = '0;
                eov_d = io.rx_valid;
                if (io.pkt_ready) begin
                    if (last_rd) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_d = rd_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            rd_q    <= 8'd0;
            csum_q  <= 8'd0;
            cnt_q   <= '0;
            ecs_q   <= 1'b0;
            elen_q  <= 1'b0;
            eto_q   <= 1'b0;
            eov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            ecs_q   <= ecs_d;
            elen_q  <= elen_d;
            eto_q   <= eto_d;
            eov_q   <= eov_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[idx_q[AW-1:0]] <= io.rx_data;
        end
    end

    assign io.pkt_valid  = (state_q == S_DRAIN);
    assign io.pkt_data   = io.pkt_valid ? buf_q[rd_q[AW-1:0]] : 8'h00;
    assign io.pkt_last   = io.pkt_valid && last_rd;
    assign err_checksum  = ecs_q;
    assign err_length    = elen_q;
    assign err_timeout   = eto_q;
    assign err_overrun   = eov_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_packet_assembler.sv
// Self-checking bench: directed vector table, multi-cycle corner cases
// and randomized packets against a stream-parsing reference model.
module tb_uart_rx_packet_assembler;

    localparam int MAXL = 16;
    localparam int TO   = 50;

    typedef struct {
        int         nb;
        logic [7:0] b [20];
        int         ne;
        logic [7:0] e [16];
        int         ecs;
        int         elen;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic err_checksum, err_length, err_timeout, err_overrun, busy;

    uart_rx_packet_assembler_if io ();

    uart_rx_packet_assembler #(
        .MAX_LEN  (MAXL),
        .SYNC_BYTE(8'hAA),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .io          (io.slave),
        .err_checksum(err_checksum),
        .err_length  (err_length),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         c_cs = 0, c_len = 0, c_to = 0, c_ov = 0;
    logic [8:0] got [$];
    logic [8:0] expq [$];
    logic [7:0] stream [$];
    logic [7:0] ib [$];
    logic [7:0] ie [$];
    vec_t       tbl [$];
    int         x_cs, x_len;
    logic       rnd_rdy = 1'b0;
    logic       s_valid, s_last, s_busy, s_rst;
    logic [7:0] s_data;
    logic [3:0] s_err;
    logic       p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    int         base, b_cs, b_len, b_to, b_ov;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then step past the
    // rising edge so the caller can drive the next cycle's inputs.
    task automatic tick();
        @(negedge clk);
        s_valid = io.pkt_valid;
        s_data  = io.pkt_data;
        s_last  = io.pkt_last;
        s_busy  = busy;
        s_rst   = reset;
        s_err   = {err_checksum, err_length, err_timeout, err_overrun};
        if (s_rst) begin
            if (err_checksum) c_cs++;
            if (err_length)   c_len++;
            if (err_timeout)  c_to++;
            if (err_overrun)  c_ov++;
            if (s_valid && io.pkt_ready) got.push_back({s_last, s_data});
            if (p_rst && p_valid && !p_ready) begin
                check("stall_valid", s_valid, 1);
                check("stall_data", s_data, p_data);
                check("stall_last", s_last, p_last);
            end
        end
        p_rst   = s_rst;
        p_valid = s_valid;
        p_ready = io.pkt_ready;
        p_data  = s_data;
        p_last  = s_last;
        @(posedge clk);
        #1;
        if (rnd_rdy) io.pkt_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        io.rx_data  = b;
        io.rx_valid = 1'b1;
        tick();
        io.rx_valid = 1'b0;
    endtask

    task automatic snap();
        base = got.size();
        b_cs = c_cs; b_len = c_len; b_to = c_to; b_ov = c_ov;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        do begin
            tick();
            k++;
        end while (s_busy && k < max);
        check("idle_wait", s_busy, 0);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic addv(input int ecs, input int elen);
        vec_t v;
        v.nb = ib.size();
        v.ne = ie.size();
        for (int i = 0; i < 20; i++) v.b[i] = (i < v.nb) ? ib[i] : 8'h00;
        for (int i = 0; i < 16; i++) v.e[i] = (i < v.ne) ? ie[i] : 8'h00;
        v.ecs  = ecs;
        v.elen = elen;
        tbl.push_back(v);
    endtask

    // Reference: scan the whole byte stream with the packet rules.
    task automatic model();
        int         i, n, l;
        logic [7:0] x;
        i = 0;
        n = stream.size();
        x_cs = 0;
        x_len = 0;
        expq.delete();
        while (i < n) begin
            if (stream[i] != 8'hAA) begin
                i++;
            end else if (i + 1 >= n) begin
                i = n;
            end else begin
                l = int'(stream[i+1]);
                if (l == 0 || l > MAXL) begin
                    x_len++;
                    i += 2;
                end else if (i + 2 + l >= n) begin
                    i = n;
                end else begin
                    x = stream[i+1];
                    for (int j = 0; j < l; j++) x ^= stream[i+2+j];
                    if (stream[i+2+l] == x) begin
                        for (int j = 0; j < l; j++)
                            expq.push_back({j == l - 1, stream[i+2+j]});
                    end else begin
                        x_cs++;
                    end
                    i += 3 + l;
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        io.rx_data   = 8'h00;
        io.rx_valid  = 1'b0;
        io.pkt_ready = 1'b0;

        ib = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        ie = '{8'h11, 8'h22, 8'h33};
        addv(0, 0);
        ib = '{8'hAA, 8'h02, 8'h55, 8'h66, 8'h00};
        ie.delete();
        addv(1, 0);
        ib = '{8'hAA, 8'h01, 8'h7E, 8'h7F};
        ie = '{8'h7E};
        addv(0, 0);
        ib = '{8'hAA, 8'h00};
        ie.delete();
        addv(0, 1);
        ib = '{8'hAA, 8'h11};
        addv(0, 1);
        ib = '{8'h00, 8'hFF, 8'h12, 8'hAA, 8'h01, 8'hAA, 8'hAB};
        ie = '{8'hAA};
        addv(0, 0);
        ib = '{8'hAA, 8'h10};
        ie.delete();
        for (int i = 0; i < 16; i++) begin
            ib.push_back(8'(i * 17));
            ie.push_back(8'(i * 17));
        end
        ib.push_back(8'h10);
        addv(0, 0);

        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_valid", s_valid, 0);
        check("rst_busy", s_busy, 0);
        check("rst_data", s_data, 0);
        check("rst_last", s_last, 0);
        check("rst_err", s_err, 0);

        // Latency and back-to-back delivery of a good packet.
        io.pkt_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        check("lat_pre", s_valid, 0);
        tick();
        check("lat_v0", s_valid, 1);
        check("lat_d0", s_data, 8'h11);
        check("lat_l0", s_last, 0);
        tick();
        check("lat_d1", {s_valid, s_data, s_last}, {1'b1, 8'h22, 1'b0});
        tick();
        check("lat_d2", {s_valid, s_data, s_last}, {1'b1, 8'h33, 1'b1});
        tick();
        check("lat_end_valid", s_valid, 0);
        check("lat_end_busy", s_busy, 0);

        foreach (tbl[k]) begin
            snap();
            for (int i = 0; i < tbl[k].nb; i++) send_byte(tbl[k].b[i]);
            repeat (25) tick();
            check($sformatf("v%0d_cnt", k), got.size() - base, tbl[k].ne);
            for (int i = 0; i < tbl[k].ne && base + i < got.size(); i++)
                check($sformatf("v%0d_b%0d", k, i), got[base+i],
                      {i == tbl[k].ne - 1, tbl[k].e[i]});
            check($sformatf("v%0d_cs", k), c_cs - b_cs, tbl[k].ecs);
            check($sformatf("v%0d_len", k), c_len - b_len, tbl[k].elen);
            check($sformatf("v%0d_to", k), c_to - b_to, 0);
            check($sformatf("v%0d_ov", k), c_ov - b_ov, 0);
            check($sformatf("v%0d_busy", k), s_busy, 0);
        end

        // Silence after a payload byte: timeout exactly TO cycles later.
        snap();
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
        repeat (TO) tick();
        check("to_early", c_to - b_to, 0);
        tick();
        check("to_edge", s_err[1], 1);
        tick();
        check("to_width", c_to - b_to, 1);
        check("to_busy", s_busy, 0);

        // A byte landing on the expiry cycle wins.
        snap();
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
        repeat (TO - 2) tick();
        send_byte(8'h20);
        send_byte(8'h32);
        repeat (6) tick();
        check("tw_to", c_to - b_to, 0);
        check("tw_cnt", got.size() - base, 2);
        if (got.size() >= base + 2) begin
            check("tw_b0", got[base], {1'b0, 8'h10});
            check("tw_b1", got[base+1], {1'b1, 8'h20});
        end

        // Stalled drain, overrun injection, then toggling ready.
        snap();
        io.pkt_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'hA1);
        send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD3);
        repeat (5) tick();
        check("bp_hold", {s_valid, s_data, s_last}, {1'b1, 8'hA1, 1'b0});
        send_byte(8'hAA);
        tick();
        check("bp_ov", c_ov - b_ov, 1);
        check("bp_after_ov", {s_valid, s_data}, {1'b1, 8'hA1});
        for (int k = 0; k < 40 && busy; k++) begin
            io.pkt_ready = ~io.pkt_ready;
            tick();
        end
        io.pkt_ready = 1'b1;
        wait_idle(10);
        check("bp_cnt", got.size() - base, 3);
        if (got.size() >= base + 3) begin
            check("bp_b0", got[base], {1'b0, 8'hA1});
            check("bp_b1", got[base+1], {1'b0, 8'hB2});
            check("bp_b2", got[base+2], {1'b1, 8'hC3});
        end
        check("bp_err", (c_cs - b_cs) + (c_len - b_len) + (c_to - b_to), 0);

        // Reset during payload, then during drain.
        snap();
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        reset_pulse();
        check("rp_state", {s_valid, s_busy, s_data, s_last}, 0);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        repeat (5) tick();
        check("rp_cnt", got.size() - base, 1);
        if (got.size() > base) check("rp_b0", got[base], {1'b1, 8'h7E});
        snap();
        io.pkt_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'hC1);
        send_byte(8'hC2); send_byte(8'h01);
        tick();
        check("rd_drain", s_valid, 1);
        reset_pulse();
        check("rd_state", {s_valid, s_busy, s_data, s_last}, 0);
        io.pkt_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05); send_byte(8'h04);
        repeat (5) tick();
        check("rd_cnt", got.size() - base, 1);
        if (got.size() > base) check("rd_b0", got[base], {1'b1, 8'h05});
        check("rst_noerr", (c_cs - b_cs) + (c_len - b_len) +
                           (c_to - b_to) + (c_ov - b_ov), 0);

        // Randomized packets with random ready.
        snap();
        rnd_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int         kind, l;
            logic [7:0] x, g;
            ib.delete();
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                ib.push_back(g == 8'hAA ? 8'h55 : g);
            end
            kind = $urandom_range(0, 3);
            ib.push_back(8'hAA);
            if (kind == 3) begin
                l = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(MAXL + 1, 255);
                ib.push_back(8'(l));
            end else begin
                l = $urandom_range(1, MAXL);
                ib.push_back(8'(l));
                x = 8'(l);
                for (int j = 0; j < l; j++) begin
                    g = 8'($urandom_range(0, 255));
                    ib.push_back(g);
                    x ^= g;
                end
                if (kind == 2) x ^= 8'($urandom_range(1, 255));
                ib.push_back(x);
            end
            foreach (ib[j]) begin
                repeat ($urandom_range(0, 3)) tick();
                send_byte(ib[j]);
                stream.push_back(ib[j]);
            end
            wait_idle(300);
        end
        rnd_rdy = 1'b0;
        io.pkt_ready = 1'b1;
        repeat (3) tick();
        model();
        check("rnd_cnt", got.size() - base, expq.size());
        for (int i = 0; i < expq.size() && base + i < got.size(); i++)
            check($sformatf("rnd_b%0d", i), got[base+i], expq[i]);
        check("rnd_cs", c_cs - b_cs, x_cs);
        check("rnd_len", c_len - b_len, x_len);
        check("rnd_to", c_to - b_to, 0);
        check("rnd_ov", c_ov - b_ov, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
